// File: rtl/mul4_fitness_sequencer.sv
// rtl/mul4_fitness_sequencer.sv - drives test vectors into a mul4 candidate and scores its outputs
// Exhaustive vector 0, then LFSR-derived vectors; reports the matching-bit count via a done pulse.
module mul4_fitness_sequencer #(
  parameter int LANES   = 16,
  parameter int NUM_VEC = 16,
  parameter int FIT_W   = $clog2(NUM_VEC*4*LANES+1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [15:0]      seed,
  output logic             busy,
  output logic             done,
  output logic [FIT_W-1:0] fitness,
  output logic             perfect,
  output logic [LANES-1:0] cand_a1,
  output logic [LANES-1:0] cand_a0,
  output logic [LANES-1:0] cand_b1,
  output logic [LANES-1:0] cand_b0,
  input  logic [LANES-1:0] cand_y3,
  input  logic [LANES-1:0] cand_y2,
  input  logic [LANES-1:0] cand_y1,
  input  logic [LANES-1:0] cand_y0
);

  localparam int SCORE_W = $clog2(4*LANES+1);
  localparam int VC_W    = (NUM_VEC > 1) ? $clog2(NUM_VEC) : 1;
  localparam logic [FIT_W-1:0] MAX_FIT      = FIT_W'(NUM_VEC*4*LANES);
  localparam logic [VC_W-1:0]  LAST_VEC     = VC_W'(NUM_VEC-1);
  localparam logic [15:0]      DEFAULT_SEED = 16'hACE1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [FIT_W-1:0]   acc_q, acc_d;
  logic [FIT_W-1:0]   fitness_q, fitness_d;
  logic               perfect_q, perfect_d;
  logic [VC_W-1:0]    vec_cnt_q, vec_cnt_d;
  logic [15:0]        lfsr_q, lfsr_d;
  logic [LANES-1:0]   a1_q, a1_d, a0_q, a0_d, b1_q, b1_d, b0_q, b0_d;

  logic [SCORE_W-1:0] score;
  logic [FIT_W-1:0]   acc_sum;
  logic [15:0]        lfsr_next;

  // Taps 16,14,13,11 map to bits 15,13,12,10; shift left with feedback into bit 0.
  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
  endfunction

  function automatic logic [15:0] bitrev16(input logic [15:0] l);
    logic [15:0] r;
    for (int i = 0; i < 16; i++) r[i] = l[4'(15 - i)];
    return r;
  endfunction

  // Lane j takes bit (j mod 16): replicates for wide slices, truncates for narrow ones.
  function automatic logic [LANES-1:0] spread(input logic [15:0] w);
    logic [LANES-1:0] r;
    for (int j = 0; j < LANES; j++) r[j] = w[4'(j)];
    return r;
  endfunction

  // Exhaustive pattern: bit b of the lane index (mod 16).
  function automatic logic [LANES-1:0] lane_idx_bit(input int b);
    logic [LANES-1:0] r;
    logic [3:0]       jj;
    for (int j = 0; j < LANES; j++) begin
      jj   = 4'(j);
      r[j] = jj[b];
    end
    return r;
  endfunction

  always_comb begin
    logic [3:0] ga, gb, g, y, m;
    score = '0;
    for (int j = 0; j < LANES; j++) begin
      ga    = {2'b00, a1_q[j], a0_q[j]};
      gb    = {2'b00, b1_q[j], b0_q[j]};
      g     = ga * gb;
      y     = {cand_y3[j], cand_y2[j], cand_y1[j], cand_y0[j]};
      m     = ~(y ^ g);
      score = score + SCORE_W'($countones(m));
    end
  end

  assign acc_sum   = acc_q + FIT_W'(score);
  assign lfsr_next = lfsr_step(lfsr_q);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    fitness_d = fitness_q;
    perfect_d = perfect_q;
    vec_cnt_d = vec_cnt_q;
    lfsr_d    = lfsr_q;
    a1_d      = a1_q;
    a0_d      = a0_q;
    b1_d      = b1_q;
    b0_d      = b0_q;
    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d   = S_RUN;
          acc_d     = '0;
          vec_cnt_d = '0;
          fitness_d = '0;
          perfect_d = 1'b0;
          lfsr_d    = (seed == 16'h0000) ? DEFAULT_SEED : seed;
          a1_d      = lane_idx_bit(3);
          a0_d      = lane_idx_bit(2);
          b1_d      = lane_idx_bit(1);
          b0_d      = lane_idx_bit(0);
        end
      end
      S_RUN: begin
        if (abort) begin
          state_d = S_IDLE;
          a1_d    = '0;
          a0_d    = '0;
          b1_d    = '0;
          b0_d    = '0;
        end else begin
          acc_d     = acc_sum;
          lfsr_d    = lfsr_next;
          vec_cnt_d = vec_cnt_q + 1'b1;
          if (vec_cnt_q == LAST_VEC) begin
            state_d   = S_DONE;
            fitness_d = acc_sum;
            perfect_d = (acc_sum == MAX_FIT);
            a1_d      = '0;
            a0_d      = '0;
            b1_d      = '0;
            b0_d      = '0;
          end else begin
            a0_d = spread(lfsr_next);
            a1_d = spread(bitrev16(lfsr_next));
            b0_d = spread({lfsr_next[10:0], lfsr_next[15:11]});
            b1_d = spread(~{lfsr_next[4:0], lfsr_next[15:5]});
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      fitness_q <= '0;
      perfect_q <= 1'b0;
      vec_cnt_q <= '0;
      lfsr_q    <= '0;
      a1_q      <= '0;
      a0_q      <= '0;
      b1_q      <= '0;
      b0_q      <= '0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      fitness_q <= fitness_d;
      perfect_q <= perfect_d;
      vec_cnt_q <= vec_cnt_d;
      lfsr_q    <= lfsr_d;
      a1_q      <= a1_d;
      a0_q      <= a0_d;
      b1_q      <= b1_d;
      b0_q      <= b0_d;
    end
  end

  assign busy    = (state_q == S_RUN);
  assign done    = (state_q == S_DONE);
  assign fitness = fitness_q;
  assign perfect = perfect_q;
  assign cand_a1 = a1_q;
  assign cand_a0 = a0_q;
  assign cand_b1 = b1_q;
  assign cand_b0 = b0_q;

endmodule
